// File: rtl/mem_app_pkg.sv
// rtl/mem_app_pkg.sv - shared constants and types for the memory application with auto-scan
// Purpose: seven-segment hex table, segment bit positions and the read-mode enum.
// Ports: none (package).
package mem_app_pkg;

   // Segment bit positions within the {dp,g,f,e,d,c,b,a} segment bus.
   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Hex digit 0-F to active-high segments, dp off.
   localparam logic [7:0] SEG_TABLE [16] = '{
      8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
   };

   typedef enum logic {
      MODE_MANUAL = 1'b0,
      MODE_AUTO   = 1'b1
   } mode_e;

endpackage

// File: rtl/mem_app_scan_seg7_scan.sv
// rtl/mem_app_scan_seg7_scan.sv - multiplexed hex seven-segment driver (module seg7_scan)
// Purpose: steps a digit counter every SCAN_DIV cycles, decodes the selected nibble
//          of dout and drives registered digit-select and segment outputs.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   dout [WIDTH]    word to display
//   dp_req          light the decimal point while digit 0 is active
//   os_com [DIGITS] one-hot active-low digit select (registered)
//   os_ens [8]      {dp,g,f,e,d,c,b,a} active-high segments (registered)
module seg7_scan
   import mem_app_pkg::*;
#(
   parameter int WIDTH    = 9,
   parameter int DIGITS   = (WIDTH + 3) / 4,
   parameter int SCAN_DIV = 50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  dout,
   input  logic              dp_req,
   output logic [DIGITS-1:0] os_com,
   output logic [7:0]        os_ens
);

   localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0]     DIV_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [DW-1:0]     DIG_LAST  = DW'(DIGITS - 1);
   localparam logic [DIGITS-1:0] COM_RESET = ~DIGITS'(1);

   logic [CW-1:0]       div_q, div_d;
   logic [DW-1:0]       digit_q, digit_d;
   logic [DIGITS-1:0]   os_com_q, os_com_d;
   logic [7:0]          os_ens_q, os_ens_d;
   logic [4*DIGITS-1:0] padded;
   logic [3:0]          nib;

   always_comb begin
      // Zero-extend to whole nibbles so the top digit reads unused bits as 0.
      padded = '0;
      padded[WIDTH-1:0] = dout;
      nib = 4'h0;
      os_com_d = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (digit_q == DW'(i)) begin
            nib = padded[4*i +: 4];
            os_com_d[i] = 1'b0;
         end
      end
      os_ens_d = SEG_TABLE[nib];
      if (dp_req && (digit_q == '0)) begin
         os_ens_d[SEG_DP] = 1'b1;
      end

      div_d   = div_q + CW'(1);
      digit_d = digit_q;
      if (div_q == DIV_LAST) begin
         div_d   = '0;
         digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q    <= '0;
         digit_q  <= '0;
         os_com_q <= COM_RESET;
         os_ens_q <= SEG_TABLE[0];
      end else begin
         div_q    <= div_d;
         digit_q  <= digit_d;
         os_com_q <= os_com_d;
         os_ens_q <= os_ens_d;
      end
   end

   assign os_com = os_com_q;
   assign os_ens = os_ens_q;

endmodule

// File: rtl/mem_app_scan.sv
// rtl/mem_app_scan.sv - register file with registered read, auto-scan and hex display
// Purpose: DEPTH x WIDTH memory written with active-low WR, read into DOUT with
//          active-low RD (manual) or by a timed address walk (auto-scan), and the
//          read word shown on a multiplexed seven-segment display.
// Build option: MEM_APP_AUTOSCAN_EN builds auto-scan, its ADV_DIV divider and the
//          dp indicator; without it MODE is ignored and SCAN_ADDR reads 0.
// Ports:
//   CLK, RST        clock and synchronous active-high reset
//   WR, RD          active-low write / read strobes
//   MODE            0 manual read, 1 auto-scan
//   A1, A2, D_IN    write address, manual read address, write data
//   DOUT, DOUT_VLD  registered read word and its one-cycle load pulse
//   SCAN_ADDR       address currently shown by auto-scan
//   oS_COM, oS_ENS  digit select (one-hot, active-low) and segments
module mem_app_scan
   import mem_app_pkg::*;
#(
   parameter  int DEPTH    = 8,
   parameter  int WIDTH    = 9,
   parameter  int SCAN_DIV = 50000,
   parameter  int ADV_DIV  = 50000000,
   localparam int AW       = $clog2(DEPTH),
   localparam int DIGITS   = (WIDTH + 3) / 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              WR,
   input  logic              RD,
   input  logic              MODE,
   input  logic [AW-1:0]     A1,
   input  logic [AW-1:0]     A2,
   input  logic [WIDTH-1:0]  D_IN,
   output logic [WIDTH-1:0]  DOUT,
   output logic              DOUT_VLD,
   output logic [AW-1:0]     SCAN_ADDR,
   output logic [DIGITS-1:0] oS_COM,
   output logic [7:0]        oS_ENS
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_vld_q, dout_vld_d;

   logic             auto_mode;
   logic             scan_load;
   logic [AW-1:0]    scan_load_addr;
   logic             dp_req;

`ifdef MEM_APP_AUTOSCAN_EN
   localparam int ADV_W = $clog2(ADV_DIV);
   localparam logic [ADV_W-1:0] ADV_LAST = ADV_W'(ADV_DIV - 1);

   logic [ADV_W-1:0] adv_cnt_q, adv_cnt_d;
   logic [AW-1:0]    scan_addr_q, scan_addr_d;
   logic             mode_prev_q, mode_prev_d;

   assign auto_mode = (mode_e'(MODE) == MODE_AUTO);
   assign dp_req    = auto_mode;

   always_comb begin
      // Divider free-runs in either mode; only the auto-scan path acts on it.
      adv_cnt_d      = (adv_cnt_q == ADV_LAST) ? '0 : adv_cnt_q + ADV_W'(1);
      scan_addr_d    = scan_addr_q;
      scan_load      = 1'b0;
      scan_load_addr = scan_addr_q;
      mode_prev_d    = auto_mode;
      if (auto_mode && !mode_prev_q) begin
         // Entering auto-scan: restart the step timer and show the current address.
         adv_cnt_d = '0;
         scan_load = 1'b1;
      end else if (auto_mode && (adv_cnt_q == ADV_LAST)) begin
         // DEPTH is a power of two, so the AW-bit increment wraps DEPTH-1 -> 0.
         scan_addr_d    = scan_addr_q + AW'(1);
         scan_load      = 1'b1;
         scan_load_addr = scan_addr_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         adv_cnt_q   <= '0;
         scan_addr_q <= '0;
         mode_prev_q <= 1'b0;
      end else begin
         adv_cnt_q   <= adv_cnt_d;
         scan_addr_q <= scan_addr_d;
         mode_prev_q <= mode_prev_d;
      end
   end

   assign SCAN_ADDR = scan_addr_q;
`else
   logic        unused_mode;
   logic [31:0] unused_adv_div;

   assign unused_mode    = MODE;
   assign unused_adv_div = 32'(ADV_DIV);
   assign auto_mode      = 1'b0;
   assign dp_req         = 1'b0;
   assign scan_load      = 1'b0;
   assign scan_load_addr = '0;
   assign SCAN_ADDR      = '0;
`endif

   always_comb begin
      mem_d = mem_q;
      if (!WR) begin
         mem_d[A1] = D_IN;
      end
      // Reads use mem_q, so a same-edge write to the read address returns the old word.
      dout_d     = dout_q;
      dout_vld_d = 1'b0;
      if (scan_load) begin
         dout_d     = mem_q[scan_load_addr];
         dout_vld_d = 1'b1;
      end else if (!auto_mode && !RD) begin
         dout_d     = mem_q[A2];
         dout_vld_d = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         dout_q     <= dout_d;
         dout_vld_q <= dout_vld_d;
      end
   end

   assign DOUT     = dout_q;
   assign DOUT_VLD = dout_vld_q;

   seg7_scan #(
      .WIDTH    (WIDTH),
      .DIGITS   (DIGITS),
      .SCAN_DIV (SCAN_DIV)
   ) u_seg7_scan (
      .clk    (CLK),
      .rst    (RST),
      .dout   (dout_q),
      .dp_req (dp_req),
      .os_com (oS_COM),
      .os_ens (oS_ENS)
   );

endmodule

// File: tb/tb_mem_app_scan.sv
// tb/tb_mem_app_scan.sv - self-checking bench for mem_app_scan
module tb_mem_app_scan;

   localparam int DEPTH    = 8;
   localparam int WIDTH    = 9;
   localparam int SCAN_DIV = 4;
   localparam int ADV_DIV  = 16;
   localparam int AW       = $clog2(DEPTH);
   localparam int DIGITS   = (WIDTH + 3) / 4;
`ifdef MEM_APP_AUTOSCAN_EN
   localparam bit AUTO_EN = 1'b1;
`else
   localparam bit AUTO_EN = 1'b0;
`endif

   logic              CLK;
   logic              RST;
   logic              WR;
   logic              RD;
   logic              MODE;
   logic [AW-1:0]     A1;
   logic [AW-1:0]     A2;
   logic [WIDTH-1:0]  D_IN;
   logic [WIDTH-1:0]  DOUT;
   logic              DOUT_VLD;
   logic [AW-1:0]     SCAN_ADDR;
   logic [DIGITS-1:0] oS_COM;
   logic [7:0]        oS_ENS;

   int vectors;
   int miscompares;

   // Reference model state (values expected after the most recent edge).
   logic [WIDTH-1:0]  mem_m [DEPTH];
   logic [WIDTH-1:0]  m_dout;
   logic              m_vld;
   int                m_scan;
   int                m_n;
   int                m_since;
   bit                m_prev_auto;
   logic [DIGITS-1:0] m_com;
   logic [7:0]        m_ens;

   mem_app_scan #(
      .DEPTH    (DEPTH),
      .WIDTH    (WIDTH),
      .SCAN_DIV (SCAN_DIV),
      .ADV_DIV  (ADV_DIV)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .WR        (WR),
      .RD        (RD),
      .MODE      (MODE),
      .A1        (A1),
      .A2        (A2),
      .D_IN      (D_IN),
      .DOUT      (DOUT),
      .DOUT_VLD  (DOUT_VLD),
      .SCAN_ADDR (SCAN_ADDR),
      .oS_COM    (oS_COM),
      .oS_ENS    (oS_ENS)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [7:0] seg_of(input int v);
      case (v)
         0: return 8'h3F;   1: return 8'h06;   2: return 8'h5B;   3: return 8'h4F;
         4: return 8'h66;   5: return 8'h6D;   6: return 8'h7D;   7: return 8'h07;
         8: return 8'h7F;   9: return 8'h6F;  10: return 8'h77;  11: return 8'h7C;
        12: return 8'h39;  13: return 8'h5E;  14: return 8'h79;  default: return 8'h71;
      endcase
   endfunction

   // Advance the model by one edge using the inputs currently driven, then clock the DUT.
   task automatic tick();
      int  pre_dout;
      int  pre_n;
      int  dig;
      bit  auto_now;
      pre_dout = int'(m_dout);
      pre_n    = m_n;
      auto_now = AUTO_EN && MODE;
      if (RST) begin
         for (int k = 0; k < DEPTH; k++) mem_m[k] = '0;
         m_dout = '0;
         m_vld = 1'b0;
         m_scan = 0;
         m_n = 0;
         m_since = 0;
         m_prev_auto = 1'b0;
         m_com = ~DIGITS'(1);
         m_ens = 8'h3F;
      end else begin
         dig   = (pre_n / SCAN_DIV) % DIGITS;
         m_com = ~(DIGITS'(1) << dig);
         m_ens = seg_of((pre_dout >> (4 * dig)) & 15);
         if (auto_now && dig == 0) m_ens = m_ens | 8'h80;
         m_vld = 1'b0;
         if (auto_now) begin
            if (!m_prev_auto) begin
               m_since = 0;
               m_dout = mem_m[m_scan];
               m_vld = 1'b1;
            end else begin
               m_since++;
               if (m_since % ADV_DIV == 0) begin
                  m_scan = (m_scan + 1) % DEPTH;
                  m_dout = mem_m[m_scan];
                  m_vld = 1'b1;
               end
            end
         end else if (!RD) begin
            m_dout = mem_m[A2];
            m_vld = 1'b1;
         end
         if (!WR) mem_m[A1] = D_IN;
         m_prev_auto = auto_now;
         m_n++;
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1; WR = 1'b1; RD = 1'b1; MODE = 1'b0;
      A1 = '0; A2 = '0; D_IN = '0;
      tick();
      tick();
      vectors++;
      if (DOUT !== 9'h000) begin miscompares++; $display("FAIL reset_dout got %h want 000", DOUT); end
      vectors++;
      if (DOUT_VLD !== 1'b0) begin miscompares++; $display("FAIL reset_vld got %b want 0", DOUT_VLD); end
      vectors++;
      if (SCAN_ADDR !== 3'd0) begin miscompares++; $display("FAIL reset_scan got %0d want 0", SCAN_ADDR); end
      vectors++;
      if (oS_COM !== 3'b110) begin miscompares++; $display("FAIL reset_com got %b want 110", oS_COM); end
      vectors++;
      if (oS_ENS !== 8'h3F) begin miscompares++; $display("FAIL reset_ens got %h want 3f", oS_ENS); end
      RST = 1'b0;
   endtask

   task automatic test_write_read();
      WR = 1'b0; A1 = 3'd5; D_IN = 9'h001;
      tick();
      A1 = 3'd0; D_IN = 9'h004;
      tick();
      WR = 1'b1; RD = 1'b0; A2 = 3'd5;
      tick();
      vectors++;
      if (DOUT !== 9'h001) begin miscompares++; $display("FAIL wr_rd_dout5 got %h want 001", DOUT); end
      vectors++;
      if (DOUT_VLD !== 1'b1) begin miscompares++; $display("FAIL wr_rd_vld got %b want 1", DOUT_VLD); end
      RD = 1'b1;
      tick();
      vectors++;
      if (DOUT_VLD !== 1'b0) begin miscompares++; $display("FAIL wr_rd_vld_end got %b want 0", DOUT_VLD); end
      vectors++;
      if (DOUT !== 9'h001) begin miscompares++; $display("FAIL wr_rd_hold got %h want 001", DOUT); end
      RD = 1'b0; A2 = 3'd0;
      tick();
      vectors++;
      if (DOUT !== 9'h004) begin miscompares++; $display("FAIL wr_rd_dout0 got %h want 004", DOUT); end
      RD = 1'b1;
      tick();
   endtask

   task automatic test_read_before_write();
      WR = 1'b0; A1 = 3'd3; D_IN = 9'h0AA;
      tick();
      RD = 1'b0; A2 = 3'd3; D_IN = 9'h155;
      tick();
      vectors++;
      if (DOUT !== 9'h0AA) begin miscompares++; $display("FAIL rbw_old got %h want 0aa", DOUT); end
      WR = 1'b1;
      tick();
      vectors++;
      if (DOUT !== 9'h155) begin miscompares++; $display("FAIL rbw_new got %h want 155", DOUT); end
      vectors++;
      if (DOUT_VLD !== 1'b1) begin miscompares++; $display("FAIL rbw_vld_held got %b want 1", DOUT_VLD); end
      RD = 1'b1;
      tick();
   endtask

   task automatic test_display();
      bit seen0, seen1, seen2;
      seen0 = 0; seen1 = 0; seen2 = 0;
      WR = 1'b0; A1 = 3'd7; D_IN = 9'h1A5;
      tick();
      WR = 1'b1; RD = 1'b0; A2 = 3'd7;
      tick();
      RD = 1'b1;
      vectors++;
      if (DOUT !== 9'h1A5) begin miscompares++; $display("FAIL disp_dout got %h want 1a5", DOUT); end
      for (int c = 0; c < 16; c++) begin
         tick();
         vectors++;
         if (oS_COM !== m_com || oS_ENS !== m_ens) begin
            miscompares++;
            $display("FAIL disp_step%0d got com=%b ens=%h want com=%b ens=%h", c, oS_COM, oS_ENS, m_com, m_ens);
         end
         if (oS_COM === 3'b110 && oS_ENS === 8'h6D) seen0 = 1;
         if (oS_COM === 3'b101 && oS_ENS === 8'h77) seen1 = 1;
         if (oS_COM === 3'b011 && oS_ENS === 8'h06) seen2 = 1;
      end
      vectors++;
      if ({seen0, seen1, seen2} !== 3'b111) begin
         miscompares++;
         $display("FAIL disp_digits got seen=%b want 111", {seen0, seen1, seen2});
      end
   endtask

   task automatic test_random_manual();
      MODE = 1'b0;
      for (int c = 0; c < 150; c++) begin
         WR   = ($urandom_range(0, 2) == 0);
         RD   = ($urandom_range(0, 2) == 0);
         A1   = AW'($urandom_range(0, DEPTH - 1));
         A2   = AW'($urandom_range(0, DEPTH - 1));
         D_IN = WIDTH'($urandom);
         tick();
         vectors++;
         if (DOUT !== m_dout || DOUT_VLD !== m_vld) begin
            miscompares++;
            $display("FAIL rand_rd%0d got dout=%h vld=%b want dout=%h vld=%b", c, DOUT, DOUT_VLD, m_dout, m_vld);
         end
      end
      WR = 1'b1; RD = 1'b1;
      tick();
   endtask

   task automatic test_autoscan();
      MODE = 1'b0; RD = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         WR = 1'b0; A1 = AW'(k); D_IN = WIDTH'(k);
         tick();
      end
      WR = 1'b1;
      MODE = 1'b1;
      for (int c = 0; c < DEPTH * ADV_DIV + 6; c++) begin
         RD = 1'($urandom);
         A2 = AW'($urandom_range(0, DEPTH - 1));
         tick();
         vectors++;
         if (DOUT !== m_dout || DOUT_VLD !== m_vld || SCAN_ADDR !== AW'(m_scan)) begin
            miscompares++;
            $display("FAIL scan%0d got dout=%h vld=%b addr=%0d want dout=%h vld=%b addr=%0d",
                     c, DOUT, DOUT_VLD, SCAN_ADDR, m_dout, m_vld, m_scan);
         end
         vectors++;
         if (oS_COM !== m_com || oS_ENS !== m_ens) begin
            miscompares++;
            $display("FAIL scan_disp%0d got com=%b ens=%h want com=%b ens=%h", c, oS_COM, oS_ENS, m_com, m_ens);
         end
      end
      RD = 1'b1;
   endtask

   task automatic test_reset_midscan();
      bit reached;
      reached = 0;
      MODE = 1'b1; RD = 1'b1; WR = 1'b1;
      for (int c = 0; c < 200 && !reached; c++) begin
         tick();
         reached = (SCAN_ADDR === 3'd4);
      end
      vectors++;
      if (reached !== AUTO_EN) begin
         miscompares++;
         $display("FAIL midscan_wait got reached=%b want %b", reached, AUTO_EN);
      end
      RST = 1'b1; WR = 1'b0; A1 = 3'd3; D_IN = 9'h1FF; RD = 1'b0; A2 = 3'd2;
      tick();
      RST = 1'b0; WR = 1'b1; RD = 1'b1; MODE = 1'b0;
      vectors++;
      if (SCAN_ADDR !== 3'd0 || DOUT !== 9'h000 || DOUT_VLD !== 1'b0) begin
         miscompares++;
         $display("FAIL midscan_rst got addr=%0d dout=%h vld=%b want 0 000 0", SCAN_ADDR, DOUT, DOUT_VLD);
      end
      for (int k = 0; k < DEPTH; k++) begin
         RD = 1'b0; A2 = AW'(k);
         tick();
         vectors++;
         if (DOUT !== 9'h000 || DOUT !== m_dout) begin
            miscompares++;
            $display("FAIL midscan_rd%0d got %h want 000", k, DOUT);
         end
      end
      RD = 1'b1;
      tick();
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_write_read();
      test_read_before_write();
      test_display();
      test_random_manual();
      test_autoscan();
      test_reset_midscan();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
